multiplier_datapath: RTL

//  Datapath driven by control_unit: 16-entry register file, 5:1 input mux, output read mux
//  and 4-function ALU. Runs the repeated-add multiply loop (A,B counters, running sum).

---
 rtl/multiplier_datapath_pkg.sv | 24 ++
 rtl/multiplier_datapath_alu.sv | 39 +++
 rtl/multiplier_datapath.sv | 63 ++++++
 3 files changed

// File: rtl/multiplier_datapath_pkg.sv
// Shared definitions for the multiplier datapath and its control unit:
// data width, ALU opcodes and write-data source codes.
package multiplier_datapath_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } alu_op_e;

  typedef enum logic [2:0] {
    SRC_A     = 3'd0,
    SRC_B     = 3'd1,
    SRC_CONST = 3'd2,
    SRC_ALU   = 3'd3,
    SRC_REG   = 3'd4
  } src_sel_e;

endpackage

// File: rtl/multiplier_datapath_alu.sv
// Combinational 4-function ALU; carry-out doubles as the no-borrow flag on SUB
// so the control unit can use one flag for both loop styles.
module dp_alu
  import multiplier_datapath_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [1:0]   i_insSel,
  output logic [W-1:0] o_aluOut,
  output logic         o_co,
  output logic         o_z
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_x} + {1'b0, i_y};
  assign w_diff = {1'b0, i_x} + {1'b0, ~i_y} + {{W{1'b0}}, 1'b1};

  always_comb begin
    o_aluOut = '0;
    o_co     = 1'b0;
    case (alu_op_e'(i_insSel))
      OP_AND: o_aluOut = i_x & i_y;
      OP_OR:  o_aluOut = i_x | i_y;
      OP_ADD: {o_co, o_aluOut} = w_sum;
      OP_SUB: {o_co, o_aluOut} = w_diff;
      default: begin
        o_aluOut = '0;
        o_co     = 1'b0;
      end
    endcase
  end

  assign o_z = ~|o_aluOut;

endmodule

// File: rtl/multiplier_datapath.sv
// Repeated-add multiplier datapath: 16-entry register file, write-data mux,
// read mux and ALU on fixed operands R1/R2. All sequencing lives in control_unit.
module multiplier_datapath
  import multiplier_datapath_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     A,
  input  logic [DW-1:0]     B,
  input  logic [DW-1:0]     CUconst,
  input  logic [1:0]        InsSel,
  input  logic [2:0]        InMuxAdd,
  input  logic [ADDR_W-1:0] OutMuxAdd,
  input  logic [ADDR_W-1:0] RegAdd,
  input  logic              we,
  output logic [DW-1:0]     RegOut,
  output logic [DW-1:0]     ALUout,
  output logic [DW-1:0]     Result,
  output logic              CO,
  output logic              Z
);

  logic [DW-1:0] r_regs [NUM_REGS];
  logic [DW-1:0] w_inMux;
  logic [DW-1:0] w_aluOut;

  always_comb begin
    w_inMux = '0;
    case (InMuxAdd)
      SRC_A:     w_inMux = A;
      SRC_B:     w_inMux = B;
      SRC_CONST: w_inMux = CUconst;
      SRC_ALU:   w_inMux = w_aluOut;
      SRC_REG:   w_inMux = RegOut;
      default:   w_inMux = '0;
    endcase
  end

  // Reset takes priority so a write issued alongside it never survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (we) begin
      r_regs[RegAdd] <= w_inMux;
    end
  end

  assign RegOut = r_regs[OutMuxAdd];
  assign Result = r_regs[3];
  assign ALUout = w_aluOut;

  dp_alu #(.W(DW)) uAlu (
    .i_x      (r_regs[1]),
    .i_y      (r_regs[2]),
    .i_insSel (InsSel),
    .o_aluOut (w_aluOut),
    .o_co     (CO),
    .o_z      (Z)
  );

endmodule
